chi_snp_responder: RTL

CHI_SNP_RESPONDER -- requirements
Module: chi_snp_responder

---
 rtl/coh_noc_pkg.sv | 126 ++++++++++++
 rtl/chi_snp_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/coh_noc_pkg.sv
// Shared coherent-NoC definitions: snoop/response/data flit layouts, opcodes,
// line-state encodings and the snoop line-state transition helper.
package coh_noc_pkg;

    typedef enum logic [1:0] {
        DIR_INVALID   = 2'b00,
        DIR_SHARED    = 2'b01,
        DIR_EXCLUSIVE = 2'b10,
        DIR_MODIFIED  = 2'b11
    } directory_state_e;

    localparam logic [7:0] SNP_SHARED           = 8'h20;
    localparam logic [7:0] SNP_CLEAN            = 8'h21;
    localparam logic [7:0] SNP_ONCE             = 8'h22;
    localparam logic [7:0] SNP_NOT_SHARED_DIRTY = 8'h23;
    localparam logic [7:0] SNP_UNIQUE           = 8'h24;
    localparam logic [7:0] SNP_CLEAN_SHARED     = 8'h25;
    localparam logic [7:0] SNP_CLEAN_INVALID    = 8'h26;
    localparam logic [7:0] SNP_MAKE_INVALID     = 8'h27;
    localparam logic [7:0] SNP_DVM_OP           = 8'h28;

    // Forwarding snoops 0x30-0x37 behave exactly like 0x20-0x27 at this node.
    localparam logic [7:0] SNP_FWD_FIRST  = 8'h30;
    localparam logic [7:0] SNP_FWD_LAST   = 8'h37;
    localparam logic [7:0] SNP_FWD_OFFSET = 8'h10;

    typedef enum logic [7:0] {
        RSP_LCRD_RETURN = 8'h00,
        RSP_SNP_RESP    = 8'h01,
        RSP_COMP_ACK    = 8'h14
    } rsp_opcode_e;

    typedef enum logic [7:0] {
        DAT_LCRD_RETURN   = 8'h00,
        DAT_SNP_RESP_DATA = 8'h01,
        DAT_COMP_DATA     = 8'h04
    } dat_opcode_e;

    localparam logic [1:0] RESP_I     = 2'b00;
    localparam logic [1:0] RESP_S     = 2'b01;
    localparam logic [1:0] RESP_E     = 2'b10;
    localparam logic [1:0] RESP_M     = 2'b11;
    localparam logic [1:0] RESP_ERROR = 2'b11;

    typedef enum logic [1:0] {
        ACT_LOOKUP,
        ACT_DVM,
        ACT_ERROR
    } snp_action_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT,
        S_SEND_RSP,
        S_SEND_DAT
    } snp_fsm_e;

    typedef struct packed {
        logic [3:0]  qos;
        logic [7:0]  tgt_id;
        logic [7:0]  src_id;
        logic [11:0] txn_id;
        logic [7:0]  fwd_node_id;
        logic [11:0] fwd_txn_id;
        logic [7:0]  opcode;
        logic [47:0] addr;
        logic        ns;
        logic        do_not_go_to_sd;
        logic        ret_to_src;
        logic        trace_tag;
    } snp_flit_t;

    typedef struct packed {
        logic [3:0]  qos;
        logic [7:0]  tgt_id;
        logic [7:0]  src_id;
        logic [11:0] txn_id;
        rsp_opcode_e opcode;
        logic [1:0]  resp_err;
        logic [1:0]  resp;
        logic [2:0]  fwd_state;
        logic [11:0] dbid;
        logic [3:0]  pcrd_type;
        logic        trace_tag;
    } rsp_flit_t;

    typedef struct packed {
        logic [3:0]   qos;
        logic [7:0]   tgt_id;
        logic [7:0]   src_id;
        logic [11:0]  txn_id;
        logic [7:0]   home_node_id;
        dat_opcode_e  opcode;
        logic [1:0]   resp_err;
        logic [1:0]   resp;
        logic [2:0]   fwd_state;
        logic [11:0]  dbid;
        logic [1:0]   ccid;
        logic [1:0]   data_id;
        logic         trace_tag;
        logic [63:0]  be;
        logic [511:0] data;
    } dat_flit_t;

    function automatic logic [1:0] state_to_resp(input directory_state_e s);
        case (s)
            DIR_SHARED:    return RESP_S;
            DIR_EXCLUSIVE: return RESP_E;
            DIR_MODIFIED:  return RESP_M;
            default:       return RESP_I;
        endcase
    endfunction

    // An invalid line never gains a state, whatever the snoop asks for.
    function automatic directory_state_e next_line_state(input logic [7:0] base_op,
                                                         input directory_state_e cur);
        if (cur == DIR_INVALID) return DIR_INVALID;
        case (base_op)
            SNP_SHARED, SNP_CLEAN, SNP_NOT_SHARED_DIRTY, SNP_CLEAN_SHARED: return DIR_SHARED;
            SNP_UNIQUE, SNP_CLEAN_INVALID, SNP_MAKE_INVALID:               return DIR_INVALID;
            default:                                                       return cur;
        endcase
    endfunction

endpackage

// File: rtl/chi_snp_responder.sv
// Single-outstanding CHI snoop responder: looks the line up, updates its state
// and answers with SnpResp or SnpRespData.
module chi_snp_responder
    import coh_noc_pkg::*;
#(
    parameter logic [7:0] NODE_ID = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snp_valid,
    output logic             snp_ready,
    input  snp_flit_t        snp_flit,
    output logic             lookup_valid,
    output logic [44:0]      lookup_addr,
    input  logic             lookup_resp_valid,
    input  directory_state_e lookup_state,
    input  logic [511:0]     lookup_data,
    output logic             upd_valid,
    output logic [44:0]      upd_addr,
    output directory_state_e upd_state,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output rsp_flit_t        rsp_flit,
    output logic             dat_valid,
    input  logic             dat_ready,
    output dat_flit_t        dat_flit,
    output logic             busy,
    output logic [15:0]      snp_count
);

    snp_fsm_e         state_q, state_d;
    logic [7:0]       src_q, src_d;
    logic [11:0]      txn_q, txn_d;
    logic             trace_q, trace_d;
    logic [44:0]      addr_q, addr_d;
    logic [7:0]       base_q, base_d;
    logic [15:0]      count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             dat_valid_q, dat_valid_d;
    rsp_flit_t        rsp_flit_q, rsp_flit_d;
    dat_flit_t        dat_flit_q, dat_flit_d;
    logic [7:0]       in_base;
    directory_state_e line_next;
    logic             unused_snp_fields;

    function automatic logic [7:0] normalize_opcode(input logic [7:0] op);
        if (op >= SNP_FWD_FIRST && op <= SNP_FWD_LAST) return op - SNP_FWD_OFFSET;
        return op;
    endfunction

    function automatic snp_action_e decode_action(input logic [7:0] base);
        if (base == SNP_DVM_OP) return ACT_DVM;
        if (base >= SNP_SHARED && base <= SNP_MAKE_INVALID) return ACT_LOOKUP;
        return ACT_ERROR;
    endfunction

    function automatic rsp_flit_t build_rsp(input logic [7:0] src, input logic [11:0] txn,
                                            input logic trace, input logic [1:0] resp);
        rsp_flit_t r;
        r           = '0;
        r.tgt_id    = src;
        r.src_id    = NODE_ID;
        r.txn_id    = txn;
        r.opcode    = RSP_SNP_RESP;
        r.resp      = resp;
        r.trace_tag = trace;
        return r;
    endfunction

    function automatic dat_flit_t build_dat(input logic [7:0] src, input logic [11:0] txn,
                                            input logic trace, input logic [1:0] resp,
                                            input logic [511:0] data);
        dat_flit_t d;
        d              = '0;
        d.tgt_id       = src;
        d.src_id       = NODE_ID;
        d.txn_id       = txn;
        d.home_node_id = src;
        d.opcode       = DAT_SNP_RESP_DATA;
        d.resp         = resp;
        d.trace_tag    = trace;
        d.be           = '1;
        d.data         = data;
        return d;
    endfunction

    assign unused_snp_fields = ^{snp_flit.qos, snp_flit.tgt_id, snp_flit.fwd_node_id,
                                 snp_flit.fwd_txn_id, snp_flit.addr[2:0], snp_flit.ns,
                                 snp_flit.do_not_go_to_sd, snp_flit.ret_to_src};

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        txn_d       = txn_q;
        trace_d     = trace_q;
        addr_d      = addr_q;
        base_d      = base_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        dat_valid_d = dat_valid_q;
        rsp_flit_d  = rsp_flit_q;
        dat_flit_d  = dat_flit_q;
        upd_valid   = 1'b0;
        in_base     = normalize_opcode(snp_flit.opcode);
        line_next   = next_line_state(base_q, lookup_state);

        case (state_q)
            S_IDLE: begin
                if (snp_valid) begin
                    src_d   = snp_flit.src_id;
                    txn_d   = snp_flit.txn_id;
                    trace_d = snp_flit.trace_tag;
                    addr_d  = snp_flit.addr[47:3];
                    base_d  = in_base;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    case (decode_action(in_base))
                        ACT_DVM: begin
                            rsp_flit_d  = build_rsp(snp_flit.src_id, snp_flit.txn_id,
                                                    snp_flit.trace_tag, RESP_I);
                            rsp_valid_d = 1'b1;
                            state_d     = S_SEND_RSP;
                        end
                        ACT_ERROR: begin
                            rsp_flit_d  = build_rsp(snp_flit.src_id, snp_flit.txn_id,
                                                    snp_flit.trace_tag, RESP_ERROR);
                            rsp_valid_d = 1'b1;
                            state_d     = S_SEND_RSP;
                        end
                        default: state_d = S_LOOKUP;
                    endcase
                end
            end
            S_LOOKUP: state_d = S_WAIT;
            S_WAIT: begin
                // Dirty data leaves with the response unless the snoop discards it.
                if (lookup_resp_valid) begin
                    upd_valid = (line_next != lookup_state);
                    if (lookup_state == DIR_MODIFIED && base_q != SNP_MAKE_INVALID) begin
                        dat_flit_d  = build_dat(src_q, txn_q, trace_q,
                                                state_to_resp(line_next), lookup_data);
                        dat_valid_d = 1'b1;
                        state_d     = S_SEND_DAT;
                    end else begin
                        rsp_flit_d  = build_rsp(src_q, txn_q, trace_q, state_to_resp(line_next));
                        rsp_valid_d = 1'b1;
                        state_d     = S_SEND_RSP;
                    end
                end
            end
            S_SEND_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_SEND_DAT: begin
                if (dat_ready) begin
                    dat_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            txn_q       <= '0;
            trace_q     <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            dat_valid_q <= 1'b0;
            rsp_flit_q  <= '0;
            dat_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            txn_q       <= txn_d;
            trace_q     <= trace_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            dat_valid_q <= dat_valid_d;
            rsp_flit_q  <= rsp_flit_d;
            dat_flit_q  <= dat_flit_d;
        end
    end

    assign snp_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign lookup_valid = (state_q == S_LOOKUP);
    assign lookup_addr  = addr_q;
    assign upd_addr     = addr_q;
    assign upd_state    = line_next;
    assign rsp_valid    = rsp_valid_q;
    assign dat_valid    = dat_valid_q;
    assign rsp_flit     = rsp_flit_q;
    assign dat_flit     = dat_flit_q;
    assign snp_count    = count_q;

endmodule
